vga_pixel_engine: RTL
=====================

// Module: vga_pixel_engine
// PURPOSE
//  Bus-mapped pixel writer for the VGA frame buffer, parametrised successor to the single-pixel VGA bus peripheral.
//  Decodes CPU bus writes to a register window. Performs single-pixel writes, with optional X/Y auto-increment.
//  Adds a hardware rectangle-fill engine that streams one pixel per clock into the frame buffer's write port (port A).
//  Sits between the processor bus and Frame_Buffer. The VGA_Sig_Gen read side is unchanged.
// PARAMETERS
//  BASE_ADDR   8'hB0  first bus address of the 7-register window
//  X_BITS      8      frame-buffer column address width
//  Y_BITS      7      frame-buffer row address width
//  X_MAX       159    last valid column
//  Y_MAX       119    last valid row
//  Y_INVERT    1      1: stored row = Y_MAX - y (origin bottom-left); 0: row = y
//  DATA_WIDTH  8      pixel data width
// PORTS
//  CLK       in   1                 system clock; the only clock
//  RESET     in   1                 asynchronous, active-high reset
//  BUS_ADDR  in   8                 CPU address bus
//  BUS_DATA  in   8                 CPU data bus (write data)
//  BUS_WE    in   1                 CPU write strobe, one cycle per write
//  FB_ADDR   out  Y_BITS+X_BITS     frame-buffer write address {row, col}
//  FB_DATA   out  DATA_WIDTH        frame-buffer write data
//  FB_WE     out  1                 frame-buffer write enable, one cycle per pixel
//  BUSY      out  1                 fill engine active
// BEHAVIOUR
//  Register map (offset from BASE_ADDR); every access is a write with BUS_WE=1:
//   +0 X    +1 Y    +2 PIXEL (write pixel at X,Y)    +3 CTRL (bit0 AUTOINC)    +4 W    +5 H    +6 FILL (colour; start fill)
//  Register widths: X/W truncate to X_BITS, Y/H truncate to Y_BITS.
//  Reset values: X=Y=W=H=CTRL=0, FSM=IDLE, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0.
//  Unlike the old peripheral, registers are random-access; there is no X->Y->PIXEL ordering.
//  All outputs are registered.
//  PIXEL write in cycle n:
//   - In cycle n+1, FB_WE=1 for exactly one cycle, FB_DATA=BUS_DATA, FB_ADDR={row(Y),X}.
//   - If X>X_MAX or Y>Y_MAX, FB_WE stays 0 (write dropped); auto-increment still applies.
//   - With AUTOINC=1: X<=X+1. If X>=X_MAX, then X<=0 and Y<=Y+1; Y wraps to 0 past Y_MAX.
//  FSM states:
//   - IDLE: decodes bus writes.
//   - FILL: entered on a FILL write in IDLE when W!=0 and H!=0. Latches colour, x0=X, y0=Y, and clipped end coordinates:
//     xe=min(X+W-1,X_MAX), ye=min(Y+H-1,Y_MAX). Compute in X_BITS+1 / Y_BITS+1 bits; no overflow.
//   - If W=0, H=0, X>X_MAX or Y>Y_MAX: FILL write is ignored; no BUSY, no writes.
//  In FILL:
//   - BUSY=1 and FB_WE=1 every cycle from n+1. Raster order: column x0..xe within row y0, then the next row, up to (xe,ye).
//   - Total writes = (xe-x0+1)*(ye-y0+1), back to back.
//   - After the last pixel (cycle n+N), the FSM returns to IDLE; BUSY=0 and FB_WE=0 in cycle n+N+1.
//   - X/Y/W/H registers are not modified by a fill.
//   - Any bus write while BUSY=1 (or in the trigger cycle's successor) is dropped entirely, including register writes.
//  Addresses outside the window, or with BUS_WE=0, are ignored.
//  RESET asserted mid-fill: immediate abort. Outputs take reset values asynchronously; no partial write follows deassertion.
//  FB_ADDR/FB_DATA hold their last value when FB_WE=0.
// TESTING
//  1. Reset; write X=5 (B0), Y=0 (B1), PIXEL=8'h3C (B2), Y_INVERT=1 -> one FB_WE pulse next cycle, FB_ADDR={7'd119,8'd5}, FB_DATA=8'h3C.
//  2. CTRL=1, X=158, Y=10, three PIXEL writes -> addresses (158,r10), (159,r10), (0,r11), where r=row(); X register then reads back as 1.
//  3. X=2,Y=3,W=3,H=2, FILL=8'hE0 -> BUSY high 6 cycles, FB_WE 6 consecutive cycles; cols 2,3,4 row(3), then row(4); BUSY low after.
//  4. Clipping: X=158,Y=118,W=10,H=10, FILL -> exactly 4 writes: (158,118), (159,118), (158,119), (159,119).
//  5. W=0, FILL -> no FB_WE, BUSY stays 0. PIXEL write issued during an active fill -> no extra FB_WE; X/Y unchanged.
//  6. Assert RESET mid-fill (after 2 of 6 writes) -> FB_WE and BUSY drop without waiting for CLK; no writes after release; FSM in IDLE.

Source files
------------

// File: rtl/vga_pixel_engine.sv
// Bus-mapped VGA frame-buffer pixel writer with a rectangle-fill engine.
// Streams one pixel per clock into the frame buffer's write port.
module vga_pixel_engine #(
  parameter logic [7:0] BASE_ADDR  = 8'hB0,
  parameter int         X_BITS     = 8,
  parameter int         Y_BITS     = 7,
  parameter int         X_MAX      = 159,
  parameter int         Y_MAX      = 119,
  parameter int         Y_INVERT   = 1,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [7:0]                 BUS_ADDR,
  input  logic [7:0]                 BUS_DATA,
  input  logic                       BUS_WE,
  output logic [Y_BITS+X_BITS-1:0]   FB_ADDR,
  output logic [DATA_WIDTH-1:0]      FB_DATA,
  output logic                       FB_WE,
  output logic                       BUSY
);

  localparam logic [X_BITS-1:0] XM  = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] YM  = Y_BITS'(Y_MAX);
  localparam logic [X_BITS:0]   XM1 = (X_BITS+1)'(X_MAX);
  localparam logic [Y_BITS:0]   YM1 = (Y_BITS+1)'(Y_MAX);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t                   r_state, w_state;
  logic [X_BITS-1:0]        r_x, w_x;
  logic [Y_BITS-1:0]        r_y, w_y;
  logic [X_BITS-1:0]        r_w, w_w;
  logic [Y_BITS-1:0]        r_h, w_h;
  logic                     r_auto, w_auto;
  logic [X_BITS-1:0]        r_x0, w_x0;
  logic [X_BITS-1:0]        r_xe, w_xe;
  logic [Y_BITS-1:0]        r_ye, w_ye;
  logic [X_BITS-1:0]        r_cx, w_cx;
  logic [Y_BITS-1:0]        r_cy, w_cy;
  logic [DATA_WIDTH-1:0]    r_col, w_col;
  logic                     r_we, w_we;
  logic [Y_BITS+X_BITS-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0]    r_data, w_data;
  logic                     r_busy, w_busy;

  logic [7:0]               w_off;
  logic                     w_hit;
  logic                     w_inb;
  logic [X_BITS:0]          w_xsum;
  logic [Y_BITS:0]          w_ysum;
  logic [X_BITS-1:0]        w_xclip;
  logic [Y_BITS-1:0]        w_yclip;

  function automatic logic [Y_BITS-1:0] f_row(
    input logic [Y_BITS-1:0] y
  );
    if (Y_INVERT != 0) return YM - y;
    else return y;
  endfunction

  assign w_off = BUS_ADDR - BASE_ADDR;
  assign w_hit = BUS_WE && (BUS_ADDR >= BASE_ADDR)
              && (w_off < 8'd7);
  assign w_inb = (r_x <= XM) && (r_y <= YM);

  // Extra bit keeps X+W-1 and Y+H-1 from wrapping before the clip.
  assign w_xsum = {1'b0, r_x} + {1'b0, r_w}
                - (X_BITS+1)'(1);
  assign w_ysum = {1'b0, r_y} + {1'b0, r_h}
                - (Y_BITS+1)'(1);
  assign w_xclip = (w_xsum > XM1) ? XM
                 : w_xsum[X_BITS-1:0];
  assign w_yclip = (w_ysum > YM1) ? YM
                 : w_ysum[Y_BITS-1:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_auto  <= 1'b0;
      r_x0    <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_w     <= w_w;
      r_h     <= w_h;
      r_auto  <= w_auto;
      r_x0    <= w_x0;
      r_xe    <= w_xe;
      r_ye    <= w_ye;
      r_cx    <= w_cx;
      r_cy    <= w_cy;
      r_col   <= w_col;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_w     = r_w;
    w_h     = r_h;
    w_auto  = r_auto;
    w_x0    = r_x0;
    w_xe    = r_xe;
    w_ye    = r_ye;
    w_cx    = r_cx;
    w_cy    = r_cy;
    w_col   = r_col;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;
    w_busy  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          case (w_off[2:0])
            3'd0: w_x = BUS_DATA[X_BITS-1:0];
            3'd1: w_y = BUS_DATA[Y_BITS-1:0];
            3'd2: begin
              if (w_inb) begin
                w_we   = 1'b1;
                w_addr = {f_row(r_y), r_x};
                w_data = BUS_DATA[DATA_WIDTH-1:0];
              end
              if (r_auto) begin
                if (r_x >= XM) begin
                  w_x = '0;
                  w_y = (r_y >= YM) ? '0
                      : r_y + Y_BITS'(1);
                end else begin
                  w_x = r_x + X_BITS'(1);
                end
              end
            end
            3'd3: w_auto = BUS_DATA[0];
            3'd4: w_w = BUS_DATA[X_BITS-1:0];
            3'd5: w_h = BUS_DATA[Y_BITS-1:0];
            3'd6: begin
              if (w_inb && (r_w != '0)
                  && (r_h != '0)) begin
                w_state = S_FILL;
                w_busy  = 1'b1;
                w_col   = BUS_DATA[DATA_WIDTH-1:0];
                w_x0    = r_x;
                w_xe    = w_xclip;
                w_ye    = w_yclip;
                w_cx    = r_x;
                w_cy    = r_y;
                w_we    = 1'b1;
                w_addr  = {f_row(r_y), r_x};
                w_data  = BUS_DATA[DATA_WIDTH-1:0];
              end
            end
            default: ;
          endcase
        end
      end
      S_FILL: begin
        // Cursor holds the pixel on the port this cycle.
        if ((r_cx == r_xe) && (r_cy == r_ye)) begin
          w_state = S_IDLE;
        end else begin
          if (r_cx == r_xe) begin
            w_cx = r_x0;
            w_cy = r_cy + Y_BITS'(1);
          end else begin
            w_cx = r_cx + X_BITS'(1);
          end
          w_busy = 1'b1;
          w_we   = 1'b1;
          w_addr = {f_row(w_cy), w_cx};
          w_data = r_col;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign FB_WE   = r_we;
  assign FB_ADDR = r_addr;
  assign FB_DATA = r_data;
  assign BUSY    = r_busy;

endmodule
